// File: rtl/ccg_pattern_sequencer.sv
// Pattern sequencer for generated combinational benchmarks: drives x-inputs,
// captures f-outputs after a settle time, compacts them into a MISR and streams records.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for start; outputs hold the last run's results
// ST_SETTLE  | dut_x held while the DUT settles; settle counter runs down
// ST_CAPTURE | record presented on cap_valid until the collector accepts it
// ST_DONE    | single-cycle completion pulse
module ccg_pattern_sequencer #(
  parameter int N_IN   = 15,
  parameter int N_OUT  = 12,
  parameter int CNT_W  = 16,
  parameter int SETTLE = 2,
  parameter logic [N_IN-1:0]  LFSR_POLY = 15'h6000,
  parameter logic [N_OUT-1:0] MISR_POLY = 12'h829
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    mode,
  input  logic [N_IN-1:0]         seed,
  input  logic [CNT_W-1:0]        num_patterns,
  output logic [N_IN-1:0]         dut_x,
  input  logic [N_OUT-1:0]        dut_f,
  output logic                    cap_valid,
  input  logic                    cap_ready,
  output logic [N_IN+N_OUT-1:0]   cap_data,
  output logic                    busy,
  output logic                    done,
  output logic [N_OUT-1:0]        signature,
  output logic [CNT_W-1:0]        pattern_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE, ST_DONE} state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] LFSR_ONE = {{(N_IN-1){1'b0}}, 1'b1};

  state_t             state, state_nxt;
  logic               mode_r;
  logic [CNT_W-1:0]   num_r;
  logic [3:0]         settle_cnt;

  logic               load_run, load_empty, do_capture, do_accept, is_last;
  logic [CNT_W-1:0]   cnt_inc;
  logic [N_IN-1:0]    seed_eff, x_next;
  logic [N_OUT-1:0]   sig_next;

  // An all-zero LFSR state would lock up, so seed 0 in LFSR mode starts at 1.
  assign seed_eff = (mode && (seed == '0)) ? LFSR_ONE : seed;
  assign x_next   = mode_r ? ((dut_x >> 1) ^ (dut_x[0] ? LFSR_POLY : '0))
                           : (dut_x + LFSR_ONE);
  assign sig_next = {signature[N_OUT-2:0], 1'b0}
                  ^ (signature[N_OUT-1] ? MISR_POLY : '0) ^ dut_f;
  assign cnt_inc  = pattern_count + 1'b1;

  always_comb begin
    state_nxt  = state;
    load_run   = 1'b0;
    load_empty = 1'b0;
    do_capture = 1'b0;
    do_accept  = 1'b0;
    is_last    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    cap_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (num_patterns == '0) begin
            load_empty = 1'b1;
            state_nxt  = ST_DONE;
          end else begin
            load_run  = 1'b1;
            state_nxt = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (settle_cnt == '0) begin
          do_capture = 1'b1;
          state_nxt  = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        busy      = 1'b1;
        cap_valid = 1'b1;
        // abort wins over a coincident handshake: the record is dropped
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (cap_ready) begin
          do_accept = 1'b1;
          is_last   = (cnt_inc == num_r);
          state_nxt = is_last ? ST_DONE : ST_SETTLE;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      mode_r        <= 1'b0;
      num_r         <= '0;
      settle_cnt    <= '0;
      dut_x         <= '0;
      cap_data      <= '0;
      signature     <= '0;
      pattern_count <= '0;
    end else begin
      state <= state_nxt;
      if (load_empty) begin
        signature     <= '0;
        pattern_count <= '0;
      end
      if (load_run) begin
        mode_r        <= mode;
        num_r         <= num_patterns;
        dut_x         <= seed_eff;
        signature     <= '0;
        pattern_count <= '0;
        settle_cnt    <= SETTLE_LD;
      end
      if ((state == ST_SETTLE) && !abort && (settle_cnt != '0))
        settle_cnt <= settle_cnt - 1'b1;
      if (do_capture) begin
        cap_data  <= {dut_x, dut_f};
        signature <= sig_next;
      end
      if (do_accept) begin
        pattern_count <= cnt_inc;
        if (!is_last) begin
          dut_x      <= x_next;
          settle_cnt <= SETTLE_LD;
        end
      end
    end
  end

endmodule

// File: doc/ccg_pattern_sequencer.md
Name: ccg_pattern_sequencer

Overview:
Built-in stimulus sequencer and response compactor for the generated combinational benchmark circuits (15-input/12-output class, e.g. the CCGRCG family after RESYN2).
- Drives the circuit's x-inputs with exhaustive-count or LFSR patterns.
- Waits a programmable settle time, then captures the f-outputs.
- Folds each capture into a MISR signature and streams {x,f} records to a collector over a valid/ready handshake.
- Used to produce golden signatures and truth-table samples for the dataset.

Parameters:
N_IN, 15, width of DUT input vector
N_OUT, 12, width of DUT output vector
CNT_W, 16, pattern counter width
SETTLE, 2, cycles dut_x is held before capture (legal range 1..15)
LFSR_POLY, 15'h6000, Galois right-shift feedback mask (x^15+x^14+1)
MISR_POLY, 12'h829, MISR feedback mask

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a run; sampled only when idle
abort  in  1  terminate the run; return to idle
mode  in  1  0 = exhaustive count, 1 = LFSR; sampled with start
seed  in  N_IN  first pattern; sampled with start
num_patterns  in  CNT_W  patterns to apply; sampled with start
dut_x  out  N_IN  drives DUT inputs
dut_f  in  N_OUT  DUT outputs
cap_valid  out  1  capture record valid
cap_ready  in  1  collector accepts record
cap_data  out  N_IN+N_OUT  {pattern, response}
busy  out  1  run in progress
done  out  1  one-cycle pulse at normal run completion
signature  out  N_OUT  MISR value; held after the run
pattern_count  out  CNT_W  records accepted this run

Behaviour:
- Reset: state IDLE. dut_x, cap_valid, cap_data, busy, done, signature and pattern_count are all 0. Reset takes priority over everything, including mid-run.
- States: IDLE, SETTLE, CAPTURE, DONE.
- Outputs by state: busy=1 in SETTLE and CAPTURE; done=1 only in DONE; cap_valid=1 only in CAPTURE.
- IDLE:
  - start=1, num_patterns=0: go to DONE; signature and pattern_count are cleared to 0.
  - start=1, num_patterns>0: latch mode and num_patterns; dut_x <= seed (mode 1 with seed 0 loads 1); signature <= 0; pattern_count <= 0; settle counter <= SETTLE-1; go to SETTLE.
  - start while busy is ignored.
- SETTLE: dut_x is held stable; the counter decrements each cycle. On the edge ending the cycle where the counter is 0:
  - cap_data <= {dut_x, dut_f};
  - signature <= {sig[N_OUT-2:0],0} ^ (sig[N_OUT-1] ? MISR_POLY : 0) ^ dut_f;
  - go to CAPTURE.
- CAPTURE:
  - cap_valid=1; cap_data, dut_x and signature are held until cap_valid&cap_ready.
  - On handshake: pattern_count++.
  - If the new count equals num_patterns, go to DONE.
  - Otherwise advance dut_x and reload the settle counter to SETTLE-1. Mode 0: dut_x+1, modulo 2^N_IN (wrap permitted). Mode 1: (dut_x>>1) ^ (dut_x[0] ? LFSR_POLY : 0).
- DONE: done=1 for exactly one cycle; next state IDLE. dut_x, signature and pattern_count keep their final values.
- Per-pattern period with cap_ready tied high: SETTLE+1 cycles. The MISR updates exactly once per pattern regardless of stall length.
- abort=1 in SETTLE or CAPTURE: next state IDLE; cap_valid drops; done is not pulsed; signature and pattern_count freeze. abort outranks a coincident handshake (that record is not counted). abort in IDLE or DONE has no effect.
- cap_valid never deasserts without a handshake, except on abort or reset.

Test Plan:
1. Loopback stub (dut_f=dut_x[11:0]), mode 0, seed 0, num_patterns=4, SETTLE=2, cap_ready=1, start at t0 -> dut_x 0,1,2,3; cap_valid at t3,t6,t9,t12; done at t13 only; signature=0x003; pattern_count=4.
2. Mode 1, seed 0 (and seed 0x0001), num_patterns=4 -> cap_data pattern fields 0x0001, 0x6000, 0x3000, 0x1800.
3. Back-pressure: cap_ready low 5 cycles at the first capture -> cap_valid, cap_data, dut_x and signature stable throughout; exactly one MISR update; record accepted on the first ready cycle.
4. num_patterns=0 -> no cap_valid, done one cycle after start, signature=0. Second start while busy -> ignored, sequence unchanged.
5. abort on the 2nd CAPTURE cycle with cap_ready=1 -> IDLE next cycle, pattern_count=1, no done pulse. Mid-run rst -> every output 0 the next cycle.
6. Real CCGRCG107 netlist as DUT, mode 0, seed 0x0500, num_patterns=2 -> f1..f7 and f12 response bits all equal (x8|x10); f9..f11 bits equal f8 in both records.
